// File: rtl/skin_classifier_if.sv
// skin_classifier_if: pixel-in / classification-out stream bundle for skin_classifier.
interface skin_classifier_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_cb;
    logic [7:0]  in_cr;
    logic        in_sof;
    logic        in_eof;
    logic        out_valid;
    logic        out_ready;
    logic        out_skin;
    logic        out_sof;
    logic        out_eof;
    logic [19:0] skin_count;
    logic        count_valid;

    modport slave (
        input  in_valid, in_cb, in_cr, in_sof, in_eof, out_ready,
        output in_ready, out_valid, out_skin, out_sof, out_eof, skin_count, count_valid
    );

    modport master (
        output in_valid, in_cb, in_cr, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, out_skin, out_sof, out_eof, skin_count, count_valid
    );
endinterface

// File: rtl/skin_classifier.sv
// skin_classifier: 5-stage rotated-ellipse skin test on transformed Cb/Cr.
// Define SKIN_COUNT_EN to add the per-frame skin pixel counter.
module skin_classifier #(
    parameter int CX     = 109,
    parameter int CY     = 152,
    parameter int COS_Q8 = -209,
    parameter int SIN_Q8 = 147,
    parameter int ECX    = 2,
    parameter int ECY    = 2,
    parameter int WA     = 4,
    parameter int WB     = 13,
    parameter int THRESH = 2560
) (
    input logic clk,
    input logic rst_n,
    skin_classifier_if.slave bus
);
    localparam logic signed [17:0] K_COS  = 18'(COS_Q8);
    localparam logic signed [17:0] K_SIN  = 18'(SIN_Q8);
    localparam logic signed [17:0] K_NSIN = 18'(-SIN_Q8);

    // bit 0 is S1, bit 4 is S5 (the output register)
    logic [4:0]         v, sof, eof;
    logic signed [8:0]  dcb, dcr;
    logic signed [17:0] p0, p1, p2, p3;
    logic signed [10:0] xd, yd;
    logic [29:0]        score;
    logic               skin;
    logic               stall;
    logic signed [18:0] sx, sy;
    logic signed [21:0] xe, ye;
    logic [21:0]        sqx, sqy;

    assign stall         = v[4] && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = v[4];
    assign bus.out_skin  = skin;
    assign bus.out_sof   = sof[4];
    assign bus.out_eof   = eof[4];

    always_comb begin
        sx  = {p0[17], p0} + {p1[17], p1};
        sy  = {p2[17], p2} + {p3[17], p3};
        xe  = {{11{xd[10]}}, xd};
        ye  = {{11{yd[10]}}, yd};
        sqx = xe * xe;
        sqy = ye * ye;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v    <= '0;
            sof  <= '0;
            eof  <= '0;
            skin <= 1'b0;
        end else if (!stall) begin
            v     <= {v[3:0], bus.in_valid};
            sof   <= {sof[3:0], bus.in_valid && bus.in_sof};
            eof   <= {eof[3:0], bus.in_valid && bus.in_eof};
            dcb   <= $signed({1'b0, bus.in_cb}) - 9'(CX);
            dcr   <= $signed({1'b0, bus.in_cr}) - 9'(CY);
            p0    <= K_COS * $signed({{9{dcb[8]}}, dcb});
            p1    <= K_SIN * $signed({{9{dcr[8]}}, dcr});
            p2    <= K_NSIN * $signed({{9{dcb[8]}}, dcb});
            p3    <= K_COS * $signed({{9{dcr[8]}}, dcr});
            xd    <= 11'(sx >>> 8) - 11'(ECX);
            yd    <= 11'(sy >>> 8) - 11'(ECY);
            score <= 30'(WA) * {8'b0, sqx} + 30'(WB) * {8'b0, sqy};
            skin  <= score <= 30'(THRESH);
        end
    end

`ifdef SKIN_COUNT_EN
    logic [19:0] cnt, base, nxt;
    logic        xfer;

    // a start-of-frame beat discards whatever was accumulated before it
    assign xfer = v[4] && bus.out_ready;
    assign base = sof[4] ? 20'd0 : cnt;
    assign nxt  = (skin && base != 20'hFFFFF) ? base + 20'd1 : base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= '0;
            bus.skin_count  <= '0;
            bus.count_valid <= 1'b0;
        end else begin
            bus.count_valid <= xfer && eof[4];
            if (xfer) begin
                cnt <= eof[4] ? 20'd0 : nxt;
                if (eof[4]) bus.skin_count <= nxt;
            end
        end
    end
`else
    assign bus.skin_count  = '0;
    assign bus.count_valid = 1'b0;
`endif
endmodule

// File: tb/tb_skin_classifier.sv
// tb_skin_classifier: directed vectors with a scoreboard queue and a decoupled output monitor.
module tb_skin_classifier;
`ifdef SKIN_COUNT_EN
    localparam int CEN = 1;
`else
    localparam int CEN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rnd = 1'b0;
    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int last_total = 0;
    logic [2:0] q[$];

    // hand-computed: score 68, 391576, 440132, 1316, 3992, 1609, 5017, 217
    logic [7:0] vcb[8] = '{8'd109, 8'd255, 8'd0, 8'd119, 8'd129, 8'd109, 8'd109, 8'd100};
    logic [7:0] vcr[8] = '{8'd152, 8'd255, 8'd0, 8'd152, 8'd152, 8'd162, 8'd172, 8'd152};
    logic       vsk[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    skin_classifier_if bus();
    skin_classifier dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, expected completion", name);
    endtask

    task automatic send(input int idx, input logic s, input logic e);
        bus.in_cb = vcb[idx];
        bus.in_cr = vcr[idx];
        bus.in_sof = s;
        bus.in_eof = e;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready && rst_n) begin
                q.push_back({vsk[idx], s, e});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail("send_timeout");
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) fail("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic single(input int idx);
        int lat;
        send(idx, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        chk("latency", lat, 5);
        chk("skin_bit", int'(bus.out_skin), int'(vsk[idx]));
        drain();
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic [2:0] got, exp, held;
        logic pstall, ecv;
        logic [19:0] etot, cnt, base;
        pstall = 1'b0;
        ecv = 1'b0;
        etot = '0;
        cnt = '0;
        held = '0;
        forever begin
            @(negedge clk);
            chk("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
            got = {bus.out_skin, bus.out_sof, bus.out_eof};
            if (rst_n && pstall) begin
                chk("stall_valid", int'(bus.out_valid), 1);
                chk("stall_hold", int'(got), int'(held));
            end
            if (bus.count_valid || ecv) begin
                chk("count_valid", int'(bus.count_valid), int'(ecv));
                if (ecv) chk("skin_count", int'(bus.skin_count), int'(etot));
                if (bus.count_valid) begin
                    pulses++;
                    last_total = int'(bus.skin_count);
                end
            end
            ecv = 1'b0;
            if (!rst_n) begin
                q.delete();
                cnt = '0;
                pstall = 1'b0;
            end else begin
                pstall = bus.out_valid && !bus.out_ready;
                held = got;
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got beat %b, expected no output", got);
                    end else begin
                        exp = q.pop_front();
                        chk("out_beat", int'(got), int'(exp));
                        if (CEN == 1) begin
                            base = exp[1] ? 20'd0 : cnt;
                            base = base + 20'(exp[2]);
                            if (exp[0]) begin
                                ecv = 1'b1;
                                etot = base;
                                cnt = '0;
                            end else begin
                                cnt = base;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int p0;
        bus.in_valid = 1'b0;
        bus.in_cb = '0;
        bus.in_cr = '0;
        bus.in_sof = 1'b0;
        bus.in_eof = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_skin", int'(bus.out_skin), 0);
        chk("rst_out_sof", int'(bus.out_sof), 0);
        chk("rst_out_eof", int'(bus.out_eof), 0);
        chk("rst_skin_count", int'(bus.skin_count), 0);
        chk("rst_count_valid", int'(bus.count_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) single(i);

        p0 = pulses;
        rnd = 1'b1;
        for (int i = 0; i < 100; i++) send(i % 8, i % 10 == 0, i % 10 == 9);
        drain();
        rnd = 1'b0;
        chk("stream_pulses", pulses - p0, CEN * 10);

        for (int f = 0; f < 2; f++) begin
            p0 = pulses;
            for (int i = 0; i < 16; i++) send(i == 15 ? 6 : i % 8, i == 0, i == 15);
            drain();
            chk("frame_pulses", pulses - p0, CEN);
            chk("frame_count", int'(bus.skin_count), CEN * 7);
        end

        for (int i = 0; i < 3; i++) send(i, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        single(3);

        p0 = pulses;
        send(0, 1'b1, 1'b1);
        drain();
        chk("one_pixel_pulses", pulses - p0, CEN);
        chk("one_pixel_count", int'(bus.skin_count), CEN);
        chk("count_valid_idle", int'(bus.count_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/skin_classifier.md
SKIN_CLASSIFIER -- requirements
Module: skin_classifier

Interface
REQ-001 Parameters: CX 109 (Cb' ellipse centre); CY 152 (Cr' centre); COS_Q8 -209 (cos theta, signed Q8); SIN_Q8 147 (sin theta, signed Q8); ECX 2 (x offset); ECY 2 (y offset); WA 4 (x weight, unsigned 8b); WB 13 (y weight, unsigned 8b); THRESH 2560 (score limit, unsigned 24b).
REQ-002 clk  in  1  single clock; all flops rise on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 in_valid, in_ready  in, out  1, 1  input handshake.
REQ-005 in_cb, in_cr  in  8, 8  transformed chroma from the transcb/transcr stages, unsigned.
REQ-006 in_sof, in_eof  in  1, 1  first/last pixel of frame; sideband for the beat.
REQ-007 out_valid, out_ready  out, in  1, 1  output handshake.
REQ-008 out_skin  out  1  1 = pixel inside the skin ellipse.
REQ-009 out_sof, out_eof  out  1, 1  sideband delayed with the pixel.
REQ-010 skin_count, count_valid  out  20, 1  per-frame skin total and its 1-cycle strobe (SKIN_COUNT_EN only).

Function
REQ-011 Beat accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
REQ-012 Five-stage pipeline with one global enable: stall = out_valid && !out_ready; in_ready = !stall; no stage advances during stall.
REQ-013 Latency exactly 5 enabled cycles from acceptance to out_valid; throughput one pixel/cycle when out_ready is held high.
REQ-014 S1: dcb = in_cb - CX, dcr = in_cr - CY, signed 9b.
REQ-015 S2: four signed products COS_Q8*dcb, SIN_Q8*dcr, -SIN_Q8*dcb, COS_Q8*dcr, 18b each.
REQ-016 S3: x = (p0+p1)>>>8, y = (p2+p3)>>>8 (arithmetic shift, floor); then xd = x-ECX, yd = y-ECY, 11b signed.
REQ-017 S4: score = WA*xd^2 + WB*yd^2, unsigned 30b, no truncation.
REQ-018 S5: out_skin = (score <= THRESH zero-extended); valid bit and sof/eof travel through every stage.
REQ-019 Bubbles: stage valid bits clear when no beat enters; out_valid never asserts for a bubble.
REQ-020 Stall holds out_skin, out_sof, out_eof stable while out_valid && !out_ready.

Reset
REQ-021 rst_n low at a posedge: all stage valid bits, out_valid, out_skin, out_sof, out_eof, skin_count, count_valid, internal counter -> 0.
REQ-022 in_ready is 1 during and after reset; in-flight pixels are discarded, never emitted.
REQ-023 Reset has priority over stall and over any handshake in the same cycle.

Configuration
REQ-024 Macro SKIN_COUNT_EN: when defined, a 20-bit counter increments on each transferred output with out_skin=1, saturating at 0xFFFFF.
REQ-025 On transfer of an out_sof beat, the counter loads that beat's out_skin (0 or 1), discarding the prior count.
REQ-026 On transfer of an out_eof beat, skin_count <= final total including that beat, count_valid = 1 for exactly one cycle, counter -> 0; sof and eof on one beat gives a total of 0 or 1.
REQ-027 Without SKIN_COUNT_EN: no counter logic; skin_count and count_valid tied to 0; the datapath is unchanged.

Verification
REQ-028 Reset, then cb=109, cr=152, out_ready=1 -> 5 cycles later out_valid=1, out_skin=1 (score 68).
REQ-029 cb=255, cr=255 -> x=-61, y=-168, score 391576, out_skin=0.
REQ-030 Stream of 100 pixels with out_ready toggling at random -> outputs in order, none lost or duplicated, held stable under stall, in_ready=0 exactly when out_valid && !out_ready.
REQ-031 SKIN_COUNT_EN, frame of 16 pixels (sof on first, eof on last), 7 skin -> skin_count=7 with one count_valid pulse; next frame restarts from 0.
REQ-032 rst_n low for 1 cycle while 3 pixels are in flight -> no out_valid for them; the next accepted pixel appears 5 cycles later.
REQ-033 Single-pixel frame (sof=eof=1, skin) -> skin_count=1; with the macro undefined -> skin_count=0 and count_valid stays 0.
